// File: rtl/xgmii_tx_framer_if.sv
// Upstream word-stream handshake into the XGMII transmit framer.
interface xgmii_tx_framer_if;
  logic [63:0] tx_data;
  logic        tx_valid;
  logic        tx_last;
  logic [2:0]  tx_bytes;
  logic        tx_ready;

  modport master (output tx_data, tx_valid, tx_last, tx_bytes, input tx_ready);
  modport slave  (input tx_data, tx_valid, tx_last, tx_bytes, output tx_ready);
endinterface

// File: rtl/xgmii_tx_framer.sv
// MAC-side XGMII transmit framer: idles, start/preamble, data, terminate, IFG, underrun error-coding.
// States: IDLE idle/start | DATA pass words | TERM trailing terminate word | DROP discard after underrun
module xgmii_tx_framer #(
  parameter int IFG_WORDS = 2,
  parameter int CNT_W     = 32
) (
  input  logic                 xaui_clk,
  input  logic                 reset,
  input  logic                 link_up,
  xgmii_tx_framer_if.slave     tx,
  output logic [63:0]          xgmii_txd,
  output logic [7:0]           xgmii_txc,
  output logic                 tx_underrun,
  output logic [CNT_W-1:0]     frame_count,
  output logic [CNT_W-1:0]     underrun_count
);

  localparam logic [63:0] IDLE_WORD  = 64'h0707070707070707;
  localparam logic [63:0] START_WORD = 64'hD5555555555555FB;
  localparam logic [63:0] TERM_WORD  = 64'h07070707070707FD;
  localparam logic [63:0] ERR_WORD   = 64'hFEFEFEFEFEFEFEFE;
  localparam int          IFG_W      = $clog2(IFG_WORDS + 2);
  localparam logic [IFG_W-1:0] IFG_MAX = IFG_W'(IFG_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_TERM, S_DROP} state_t;

  state_t             state_q;
  logic [IFG_W-1:0]   ifg_q;
  logic               drop_first_q;
  logic [63:0]        txd_q;
  logic [7:0]         txc_q;
  logic               underrun_q;
  logic [CNT_W-1:0]   frame_cnt_q;
  logic [CNT_W-1:0]   underrun_cnt_q;

  logic [63:0]        part_d;
  logic [7:0]         part_c;

  // Short last word: data lanes below n, terminate at lane n, idles above.
  always_comb begin
    part_d = IDLE_WORD;
    part_c = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(tx.tx_bytes)) begin
        part_d[8*i +: 8] = tx.tx_data[8*i +: 8];
        part_c[i]        = 1'b0;
      end else if (i == int'(tx.tx_bytes)) begin
        part_d[8*i +: 8] = 8'hFD;
      end
    end
  end

  always_ff @(posedge xaui_clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      ifg_q          <= IFG_MAX;
      drop_first_q   <= 1'b0;
      txd_q          <= IDLE_WORD;
      txc_q          <= 8'hFF;
      underrun_q     <= 1'b0;
      frame_cnt_q    <= '0;
      underrun_cnt_q <= '0;
    end else begin
      underrun_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (tx.tx_valid && link_up && (ifg_q >= IFG_MAX)) begin
            txd_q   <= START_WORD;
            txc_q   <= 8'h01;
            state_q <= S_DATA;
          end else begin
            txd_q <= IDLE_WORD;
            txc_q <= 8'hFF;
            if (ifg_q < IFG_MAX) ifg_q <= ifg_q + IFG_W'(1);
          end
        end
        S_DATA: begin
          if (tx.tx_valid) begin
            if (tx.tx_last && (tx.tx_bytes != 3'd0)) begin
              txd_q       <= part_d;
              txc_q       <= part_c;
              frame_cnt_q <= frame_cnt_q + CNT_W'(1);
              ifg_q       <= '0;
              state_q     <= S_IDLE;
            end else begin
              txd_q <= tx.tx_data;
              txc_q <= 8'h00;
              if (tx.tx_last) state_q <= S_TERM;
            end
          end else begin
            txd_q          <= ERR_WORD;
            txc_q          <= 8'hFF;
            underrun_q     <= 1'b1;
            underrun_cnt_q <= underrun_cnt_q + CNT_W'(1);
            drop_first_q   <= 1'b1;
            state_q        <= S_DROP;
          end
        end
        S_TERM: begin
          txd_q       <= TERM_WORD;
          txc_q       <= 8'hFF;
          frame_cnt_q <= frame_cnt_q + CNT_W'(1);
          ifg_q       <= '0;
          state_q     <= S_IDLE;
        end
        S_DROP: begin
          txd_q        <= drop_first_q ? TERM_WORD : IDLE_WORD;
          txc_q        <= 8'hFF;
          drop_first_q <= 1'b0;
          if (tx.tx_valid && tx.tx_last) begin
            ifg_q   <= '0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx.tx_ready     = (state_q == S_DATA) || (state_q == S_DROP);
  assign xgmii_txd       = txd_q;
  assign xgmii_txc       = txc_q;
  assign tx_underrun     = underrun_q;
  assign frame_count     = frame_cnt_q;
  assign underrun_count  = underrun_cnt_q;

endmodule

// File: tb/tb_xgmii_tx_framer.sv
// Directed bench for xgmii_tx_framer: vector table plus hand-written underrun/link/reset sequences.
module tb_xgmii_tx_framer;

  localparam logic [63:0] IDLE  = 64'h0707070707070707;
  localparam logic [63:0] START = 64'hD5555555555555FB;
  localparam logic [63:0] TERM  = 64'h07070707070707FD;
  localparam logic [63:0] ERRW  = 64'hFEFEFEFEFEFEFEFE;

  logic        clk;
  logic        rst;
  logic        link_up;
  logic [63:0] xgmii_txd;
  logic [7:0]  xgmii_txc;
  logic        tx_underrun;
  logic [31:0] frame_count;
  logic [31:0] underrun_count;

  xgmii_tx_framer_if txif ();

  xgmii_tx_framer #(.IFG_WORDS(2), .CNT_W(32)) dut (
    .xaui_clk       (clk),
    .reset          (rst),
    .link_up        (link_up),
    .tx             (txif),
    .xgmii_txd      (xgmii_txd),
    .xgmii_txc      (xgmii_txc),
    .tx_underrun    (tx_underrun),
    .frame_count    (frame_count),
    .underrun_count (underrun_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        link;
    logic        valid;
    logic        last;
    logic [2:0]  bytes;
    logic [63:0] data;
    logic        exp_ready;
    logic [63:0] exp_txd;
    logic [7:0]  exp_txc;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic link, input logic valid, input logic last,
                              input logic [2:0] bytes, input logic [63:0] data,
                              input logic exp_ready, input logic [63:0] exp_txd,
                              input logic [7:0] exp_txc);
    vec_t v;
    v.link = link; v.valid = valid; v.last = last; v.bytes = bytes; v.data = data;
    v.exp_ready = exp_ready; v.exp_txd = exp_txd; v.exp_txc = exp_txc;
    return v;
  endfunction

  // Drive one cycle of inputs, check tx_ready before the edge and the bus after it.
  task automatic step(input string name, input vec_t v);
    link_up       = v.link;
    txif.tx_valid = v.valid;
    txif.tx_last  = v.last;
    txif.tx_bytes = v.bytes;
    txif.tx_data  = v.data;
    check({name, " ready"}, {63'd0, txif.tx_ready}, {63'd0, v.exp_ready});
    @(posedge clk);
    #1;
    check({name, " txd"}, xgmii_txd, v.exp_txd);
    check({name, " txc"}, {56'd0, xgmii_txc}, {56'd0, v.exp_txc});
  endtask

  initial begin
    rst = 1'b1;
    link_up = 1'b1;
    txif.tx_valid = 1'b0;
    txif.tx_last  = 1'b0;
    txif.tx_bytes = 3'd0;
    txif.tx_data  = '0;

    #3;
    check("reset txd", xgmii_txd, IDLE);
    check("reset txc", {56'd0, xgmii_txc}, 64'hFF);
    check("reset ready", {63'd0, txif.tx_ready}, 64'd0);
    check("reset frame_count", {32'd0, frame_count}, 64'd0);
    check("reset underrun_count", {32'd0, underrun_count}, 64'd0);
    check("reset underrun", {63'd0, tx_underrun}, 64'd0);
    #9 rst = 1'b0;
    @(posedge clk);
    #1;

    // idle, 3-word full frame, exactly 2 IFG idles, 2-word frame ending with 3 bytes
    vecs.push_back(mk(1, 0, 0, 0, 64'h0, 0, IDLE, 8'hFF));
    vecs.push_back(mk(1, 0, 0, 0, 64'h0, 0, IDLE, 8'hFF));
    vecs.push_back(mk(1, 1, 0, 0, 64'hA0A1A2A3A4A5A6A7, 0, START, 8'h01));
    vecs.push_back(mk(1, 1, 0, 0, 64'hA0A1A2A3A4A5A6A7, 1, 64'hA0A1A2A3A4A5A6A7, 8'h00));
    vecs.push_back(mk(1, 1, 0, 0, 64'hB0B1B2B3B4B5B6B7, 1, 64'hB0B1B2B3B4B5B6B7, 8'h00));
    vecs.push_back(mk(1, 1, 1, 0, 64'hC0C1C2C3C4C5C6C7, 1, 64'hC0C1C2C3C4C5C6C7, 8'h00));
    vecs.push_back(mk(1, 1, 0, 0, 64'hD0D1D2D3D4D5D6D7, 0, TERM, 8'hFF));
    vecs.push_back(mk(1, 1, 0, 0, 64'hD0D1D2D3D4D5D6D7, 0, IDLE, 8'hFF));
    vecs.push_back(mk(1, 1, 0, 0, 64'hD0D1D2D3D4D5D6D7, 0, IDLE, 8'hFF));
    vecs.push_back(mk(1, 1, 0, 0, 64'hD0D1D2D3D4D5D6D7, 0, START, 8'h01));
    vecs.push_back(mk(1, 1, 0, 0, 64'hD0D1D2D3D4D5D6D7, 1, 64'hD0D1D2D3D4D5D6D7, 8'h00));
    vecs.push_back(mk(1, 1, 1, 3, 64'h1122334455667788, 1, 64'h07070707FD667788, 8'hF8));
    vecs.push_back(mk(1, 0, 0, 0, 64'h0, 0, IDLE, 8'hFF));

    foreach (vecs[i]) step($sformatf("vec%0d", i), vecs[i]);
    check("table frame_count", {32'd0, frame_count}, 64'd2);
    check("table underrun_count", {32'd0, underrun_count}, 64'd0);

    // underrun inside a 4-word frame, remainder discarded through tx_last
    step("ur idle", mk(1, 0, 0, 0, 64'h0, 0, IDLE, 8'hFF));
    step("ur start", mk(1, 1, 0, 0, 64'h1111111111111111, 0, START, 8'h01));
    step("ur w0", mk(1, 1, 0, 0, 64'h1111111111111111, 1, 64'h1111111111111111, 8'h00));
    step("ur gap", mk(1, 0, 0, 0, 64'h0, 1, ERRW, 8'hFF));
    check("ur pulse", {63'd0, tx_underrun}, 64'd1);
    check("ur underrun_count", {32'd0, underrun_count}, 64'd1);
    step("ur w1", mk(1, 1, 0, 0, 64'h2222222222222222, 1, TERM, 8'hFF));
    check("ur pulse low", {63'd0, tx_underrun}, 64'd0);
    step("ur w2", mk(1, 1, 0, 0, 64'h3333333333333333, 1, IDLE, 8'hFF));
    step("ur w3", mk(1, 1, 1, 0, 64'h4444444444444444, 1, IDLE, 8'hFF));
    step("ur after", mk(1, 0, 0, 0, 64'h0, 0, IDLE, 8'hFF));
    check("ur frame_count", {32'd0, frame_count}, 64'd2);

    // link down holds off the start; raising it starts on the next edge
    for (int k = 0; k < 3; k++)
      step($sformatf("link down %0d", k), mk(0, 1, 1, 1, 64'hF0F1F2F3F4F5F6F7, 0, IDLE, 8'hFF));
    step("link up start", mk(1, 1, 1, 1, 64'hF0F1F2F3F4F5F6F7, 0, START, 8'h01));
    step("link 1-byte last", mk(1, 1, 1, 1, 64'hF0F1F2F3F4F5F6F7, 1, 64'h070707070707FDF7, 8'hFE));
    check("link frame_count", {32'd0, frame_count}, 64'd3);

    // asynchronous reset in the middle of a frame
    step("rs idle0", mk(1, 0, 0, 0, 64'h0, 0, IDLE, 8'hFF));
    step("rs idle1", mk(1, 0, 0, 0, 64'h0, 0, IDLE, 8'hFF));
    step("rs start", mk(1, 1, 0, 0, 64'h5A5A5A5A5A5A5A5A, 0, START, 8'h01));
    step("rs data", mk(1, 1, 0, 0, 64'h5A5A5A5A5A5A5A5A, 1, 64'h5A5A5A5A5A5A5A5A, 8'h00));
    #2 rst = 1'b1;
    #1;
    check("rs async txd", xgmii_txd, IDLE);
    check("rs async txc", {56'd0, xgmii_txc}, 64'hFF);
    check("rs async ready", {63'd0, txif.tx_ready}, 64'd0);
    check("rs frame_count", {32'd0, frame_count}, 64'd0);
    #2 rst = 1'b0;
    step("rs2 start", mk(1, 1, 0, 0, 64'h6B6B6B6B6B6B6B6B, 0, START, 8'h01));
    step("rs2 last", mk(1, 1, 1, 0, 64'h6B6B6B6B6B6B6B6B, 1, 64'h6B6B6B6B6B6B6B6B, 8'h00));
    step("rs2 term", mk(1, 0, 0, 0, 64'h0, 0, TERM, 8'hFF));
    check("rs2 frame_count", {32'd0, frame_count}, 64'd1);
    step("rs2 idle", mk(1, 0, 0, 0, 64'h0, 0, IDLE, 8'hFF));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
